yannickreiss_switch_interlock: RTL and testbench
================================================

// Module: yannickreiss_switch_interlock
// PURPOSE
//   Sequential interlocking controller for one railway diamond: four entries NW=0, SW=1, NE=2, SE=3.
//   - Arbitrates train requests round-robin and commands the crossover switch.
//   - Waits for switch feedback to settle, then clears signals, locks the route and releases it after the train passes.
//   - Clocked, fault-supervised successor to the combinational switch-diamond logic.
//   - Sits between track-side sensors/requests and signal/switch drivers.
// PARAMETERS
//   SETTLE_CYCLES  4    consecutive cycles sw_fb must equal sw_cmd before lock (>=1)
//   MOVE_TIMEOUT   64   max cycles in MOVE before FAULT
//   ENTRY_TIMEOUT  255  max cycles in LOCKED waiting for train entry before auto-release
//   CNT_W          8    shared timer width; must hold the largest of the three values above
//   PARALLEL_EN    1    1: straight lock may also grant one parallel entry
// PORTS
//   clk          in   1  clock
//   rst_n        in   1  asynchronous active-low reset
//   req          in   4  level train request per entry; held until served
//   mode         in   2  00 straight, 01 crossover, 11 auto (avoid stop), 10 reserved (= straight)
//   sw_fb        in   1  switch position feedback (0 straight, 1 diverging)
//   track_clear  in   1  1 = diamond area unoccupied
//   fault_clr    in   1  pulse; leaves FAULT
//   sig          out  4  1 = proceed aspect for entry i (0 = stop)
//   sw_cmd       out  1  switch command (0 straight, 1 diverging)
//   locked       out  1  route locked (state LOCKED)
//   fault        out  1  switch supervision fault (state FAULT)
// BEHAVIOUR
//   All outputs registered. Reset (async, rst_n=0): sig=0, sw_cmd=0, locked=0, fault=0, state IDLE,
//     rr pointer=0, timer=0. Reset mid-route drops all signals to stop immediately.
//   Track of entry i = i[0]; head-on partner = i^2. Parallel entries = other track.
//   FSM IDLE -> MOVE -> LOCKED -> IDLE; MOVE -> FAULT; FAULT -> IDLE.
//   IDLE
//     - If any req: g = first requesting entry at or after rr pointer (wrapping 3->0).
//     - Required position p: mode 01 -> 1; mode 11 -> req[g^2]; else 0.
//     - Next cycle: state MOVE, sw_cmd=p, timer=0, settle=0.
//   MOVE
//     - Timer counts every cycle.
//     - Settle counts cycles with sw_fb==sw_cmd; a mismatch resets it to 0.
//     - settle reaches SETTLE_CYCLES -> LOCKED. With sw_fb already matching, MOVE lasts exactly SETTLE_CYCLES cycles.
//     - req[g]=0 -> IDLE, no grant, pointer unchanged.
//     - Timer reaches MOVE_TIMEOUT first -> FAULT.
//   LOCKED (entry cycle)
//     - sig[g]=1.
//     - If p=0, PARALLEL_EN=1 and some entry k on the other track has req[k]=1: sig[k]=1 too (lowest such k).
//     - p=1: only g is granted.
//     - Timer restarts.
//   LOCKED (release)
//     - track_clear=0 observed: all sig -> 0 next cycle. Then wait for track_clear=1 -> IDLE.
//     - No entry within ENTRY_TIMEOUT cycles, or req[g] dropped before entry: sig -> 0, -> IDLE.
//     - On leaving LOCKED, rr pointer = g+1 mod 4. sw_cmd holds until the next IDLE->MOVE.
//   FAULT
//     - sig=0, sw_cmd held, fault=1.
//     - fault_clr=1 -> IDLE next cycle; pointer advanced past g.
//   Signals are never asserted outside LOCKED. Conflicting entries (head-on, or two diverging) are never green together.
// TESTING
//   - Reset: rst_n=0 with req=4'hF -> sig=0, sw_cmd=0, locked=0, fault=0.
//   - mode=00, req=0001, sw_fb=0 -> sig=0001 exactly 1+SETTLE_CYCLES cycles after req.
//     Then track_clear 1->0 -> sig=0; track_clear->1 -> IDLE.
//   - mode=00, req=0011 -> sig=0011 (parallel grant).
//     With PARALLEL_EN=0 -> sig=0001, then 0010 on the next route.
//   - mode=11, req=0101 -> sw_cmd=1, sig=0001 once sw_fb=1 for 4 cycles; next route grants entry 2.
//   - sw_fb stuck 0 with sw_cmd=1 -> fault=1 after 64 MOVE cycles, sig=0; fault_clr -> fault=0.
//   - req[g] dropped in LOCKED before entry -> sig=0 next cycle.
//     Also: ENTRY_TIMEOUT expiry -> release. rst_n pulse mid-LOCKED -> sig=0 immediately.

Source files
------------

// File: rtl/yannickreiss_switch_interlock.sv
// ---------------------------------------------------------------------------
// yannickreiss_switch_interlock
//   Sequential interlocking controller for one railway diamond with four
//   entries (NW=0, SW=1, NE=2, SE=3). Entry i lies on track i[0]; its
//   head-on partner is entry i^2. Requests are arbitrated round-robin. The
//   crossover switch is commanded and its feedback is supervised until it
//   settles. The route is then locked and the proceed aspect is cleared.
//   The route is released after the train has passed, on entry timeout, or
//   when the request is withdrawn.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   req[3:0]     level train request per entry, held until served
//   mode[1:0]    00 straight, 01 crossover, 11 auto, 10 treated as straight
//   sw_fb        switch position feedback (0 straight, 1 diverging)
//   track_clear  1 = diamond area unoccupied
//   fault_clr    pulse that leaves the FAULT state
//   sig[3:0]     1 = proceed aspect for entry i
//   sw_cmd       switch command (0 straight, 1 diverging)
//   locked       route locked
//   fault        switch supervision fault
// ---------------------------------------------------------------------------
module yannickreiss_switch_interlock #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MOVE_TIMEOUT  = 64,
  parameter int ENTRY_TIMEOUT = 255,
  parameter int CNT_W         = 8,
  parameter int PARALLEL_EN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [1:0] mode,
  input  logic       sw_fb,
  input  logic       track_clear,
  input  logic       fault_clr,
  output logic [3:0] sig,
  output logic       sw_cmd,
  output logic       locked,
  output logic       fault
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_LOCKED, S_FAULT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       g_q, g_d;
  logic             sw_cmd_q, sw_cmd_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [3:0]       sig_q, sig_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic             entered_q, entered_d;

  logic             pick_valid;
  logic [1:0]       pick;
  logic [1:0]       cand;
  logic             pos_req;
  logic             par_valid;
  logic [1:0]       par_k;
  logic [1:0]       kk;
  logic [CNT_W-1:0] timer_n;
  logic [CNT_W-1:0] settle_n;

  // Round-robin pick: iterate from the farthest offset down so that the
  // entry closest to the pointer is the one written last.
  always_comb begin
    pick_valid = 1'b0;
    pick       = rr_q;
    cand       = rr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_q + 2'(i);
      if (req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Auto mode diverges only when the head-on partner also waits.
  always_comb begin
    case (mode)
      2'b01:   pos_req = 1'b1;
      2'b11:   pos_req = req[pick ^ 2'd2];
      default: pos_req = 1'b0;
    endcase
  end

  // Lowest requesting entry on the track that is not used by the granted route.
  always_comb begin
    par_valid = 1'b0;
    par_k     = 2'd0;
    kk        = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      kk = 2'(k);
      if ((kk[0] != g_q[0]) && req[kk]) begin
        par_valid = 1'b1;
        par_k     = kk;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    g_d       = g_q;
    sw_cmd_d  = sw_cmd_q;
    timer_d   = timer_q;
    settle_d  = settle_q;
    sig_d     = sig_q;
    locked_d  = locked_q;
    fault_d   = fault_q;
    entered_d = entered_q;
    timer_n   = timer_q + CNT_W'(1);
    settle_n  = (sw_fb == sw_cmd_q) ? settle_q + CNT_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d  = S_MOVE;
          g_d      = pick;
          sw_cmd_d = pos_req;
          timer_d  = '0;
          settle_d = '0;
        end
      end

      // A withdrawn request abandons the route before the lock or fault checks.
      S_MOVE: begin
        if (!req[g_q]) begin
          state_d = S_IDLE;
        end else if (settle_n == CNT_W'(SETTLE_CYCLES)) begin
          state_d   = S_LOCKED;
          locked_d  = 1'b1;
          timer_d   = '0;
          entered_d = 1'b0;
          sig_d     = 4'(1) << g_q;
          if (!sw_cmd_q && (PARALLEL_EN != 0) && par_valid) begin
            sig_d = sig_d | (4'(1) << par_k);
          end
        end else if (timer_n == CNT_W'(MOVE_TIMEOUT)) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          timer_d  = timer_n;
          settle_d = settle_n;
        end
      end

      // Occupancy latches 'entered'. After that the route is held until the
      // diamond is clear again.
      S_LOCKED: begin
        if (!entered_q) begin
          if (!track_clear) begin
            sig_d     = 4'b0000;
            entered_d = 1'b1;
          end else if (!req[g_q] || (timer_n == CNT_W'(ENTRY_TIMEOUT))) begin
            sig_d    = 4'b0000;
            locked_d = 1'b0;
            state_d  = S_IDLE;
            rr_d     = g_q + 2'd1;
          end else begin
            timer_d = timer_n;
          end
        end else if (track_clear) begin
          locked_d = 1'b0;
          state_d  = S_IDLE;
          rr_d     = g_q + 2'd1;
        end
      end

      S_FAULT: begin
        sig_d = 4'b0000;
        if (fault_clr) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
          rr_d    = g_q + 2'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= 2'd0;
      g_q       <= 2'd0;
      sw_cmd_q  <= 1'b0;
      timer_q   <= '0;
      settle_q  <= '0;
      sig_q     <= 4'b0000;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
      entered_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      g_q       <= g_d;
      sw_cmd_q  <= sw_cmd_d;
      timer_q   <= timer_d;
      settle_q  <= settle_d;
      sig_q     <= sig_d;
      locked_q  <= locked_d;
      fault_q   <= fault_d;
      entered_q <= entered_d;
    end
  end

  assign sig    = sig_q;
  assign sw_cmd = sw_cmd_q;
  assign locked = locked_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_yannickreiss_switch_interlock.sv
// ---------------------------------------------------------------------------
// tb_yannickreiss_switch_interlock
//   Directed bench. Two instances share the same stimulus: u_par has
//   parallel grants enabled and u_ser has them disabled.
// ---------------------------------------------------------------------------
module tb_yannickreiss_switch_interlock;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] mode;
  logic       sw_fb;
  logic       track_clear;
  logic       fault_clr;

  logic [3:0] sig_a, sig_b;
  logic       sw_a, sw_b;
  logic       locked_a, locked_b;
  logic       fault_a, fault_b;

  int total;
  int bad;

  yannickreiss_switch_interlock #(.PARALLEL_EN(1)) u_par (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .sw_fb(sw_fb),
    .track_clear(track_clear), .fault_clr(fault_clr),
    .sig(sig_a), .sw_cmd(sw_a), .locked(locked_a), .fault(fault_a)
  );

  yannickreiss_switch_interlock #(.PARALLEL_EN(0)) u_ser (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .sw_fb(sw_fb),
    .track_clear(track_clear), .fault_clr(fault_clr),
    .sig(sig_b), .sw_cmd(sw_b), .locked(locked_b), .fault(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r, input logic [1:0] m,
                               input logic fb, input logic tc, input logic fc);
    req         = r;
    mode        = m;
    sw_fb       = fb;
    track_clear = tc;
    fault_clr   = fc;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs,
                             input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    req = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    applyStimulus(4'hF, 2'b00, 1'b0, 1'b1, 1'b0);
    #2;

    // Reset while every entry requests.
    rst_n = 1'b0;
    #2;
    checkOutput("rst_sig", sig_a, 4'b0000);
    checkOutput("rst_sw", {3'b0, sw_a}, 4'd0);
    checkOutput("rst_locked", {3'b0, locked_a}, 4'd0);
    checkOutput("rst_fault", {3'b0, fault_a}, 4'd0);
    doReset();

    // Straight single route: lock exactly 1+SETTLE_CYCLES edges after req.
    applyStimulus(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(4);
    checkOutput("single_prelock", sig_a, 4'b0000);
    tick(1);
    checkOutput("single_sig", sig_a, 4'b0001);
    checkOutput("single_locked", {3'b0, locked_a}, 4'd1);
    checkOutput("single_sig_ser", sig_b, 4'b0001);
    track_clear = 1'b0;
    tick(1);
    checkOutput("occupied_sig", sig_a, 4'b0000);
    checkOutput("occupied_locked", {3'b0, locked_a}, 4'd1);
    tick(3);
    checkOutput("occupied_hold", {3'b0, locked_a}, 4'd1);
    applyStimulus(4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("cleared_unlock", {3'b0, locked_a}, 4'd0);

    // Parallel grant on the straight route versus a serialized instance.
    doReset();
    applyStimulus(4'b0011, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(5);
    checkOutput("par_sig", sig_a, 4'b0011);
    checkOutput("nopar_sig", sig_b, 4'b0001);
    track_clear = 1'b0;
    tick(1);
    track_clear = 1'b1;
    tick(1);
    tick(5);
    checkOutput("par_sig2", sig_a, 4'b0011);
    checkOutput("nopar_sig2", sig_b, 4'b0010);
    applyStimulus(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(1);
    track_clear = 1'b1;
    tick(1);

    // Auto mode diverges when the head-on partner also waits.
    doReset();
    applyStimulus(4'b0101, 2'b11, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("auto_swcmd", {3'b0, sw_a}, 4'd1);
    sw_fb = 1'b1;
    tick(3);
    checkOutput("auto_prelock", sig_a, 4'b0000);
    tick(1);
    checkOutput("auto_sig", sig_a, 4'b0001);
    applyStimulus(4'b0100, 2'b11, 1'b1, 1'b0, 1'b0);
    tick(1);
    track_clear = 1'b1;
    tick(1);
    sw_fb = 1'b0;
    tick(1);
    checkOutput("auto2_swcmd", {3'b0, sw_a}, 4'd0);
    tick(4);
    checkOutput("auto2_sig", sig_a, 4'b0100);
    applyStimulus(4'b0000, 2'b11, 1'b0, 1'b0, 1'b0);
    tick(1);
    track_clear = 1'b1;
    tick(1);

    // Stuck feedback leads to a fault after MOVE_TIMEOUT cycles.
    doReset();
    applyStimulus(4'b0001, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("flt_swcmd", {3'b0, sw_a}, 4'd1);
    tick(63);
    checkOutput("flt_before", {3'b0, fault_a}, 4'd0);
    tick(1);
    checkOutput("flt_set", {3'b0, fault_a}, 4'd1);
    checkOutput("flt_sig", sig_a, 4'b0000);
    tick(2);
    checkOutput("flt_hold", {3'b0, fault_a}, 4'd1);
    applyStimulus(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1);
    tick(1);
    fault_clr = 1'b0;
    checkOutput("flt_clr", {3'b0, fault_a}, 4'd0);
    checkOutput("flt_sw_held", {3'b0, sw_a}, 4'd1);
    req = 4'b0011;
    tick(5);
    checkOutput("flt_ptr_adv", sig_b, 4'b0010);

    // Request withdrawn before the train enters.
    doReset();
    applyStimulus(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(5);
    checkOutput("drop_pre", sig_a, 4'b0001);
    req = 4'b0000;
    tick(1);
    checkOutput("drop_sig", sig_a, 4'b0000);
    checkOutput("drop_unlock", {3'b0, locked_a}, 4'd0);

    // Entry timeout releases the route after ENTRY_TIMEOUT locked cycles.
    doReset();
    applyStimulus(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(5);
    tick(254);
    checkOutput("eto_before", sig_a, 4'b0001);
    tick(1);
    checkOutput("eto_sig", sig_a, 4'b0000);
    checkOutput("eto_unlock", {3'b0, locked_a}, 4'd0);

    // Asynchronous reset during the locked state.
    doReset();
    applyStimulus(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(5);
    checkOutput("arst_pre", sig_a, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_sig", sig_a, 4'b0000);
    checkOutput("arst_locked", {3'b0, locked_a}, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
